// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared constants and types for the sequential binary-to-BCD converter.
// Digit codes are 7 bits wide to match the seven-segment decoder input.
package bin_to_bcd_seq_pkg;

    localparam int unsigned BIN_W       = 32;
    localparam int unsigned DIG_W       = 4;
    localparam int unsigned N_DISP_DIG  = 8;
    localparam int unsigned N_INT_DIG   = 10;
    localparam int unsigned SEG_IN_W    = 7;
    localparam int unsigned ADD3_THRESH = 5;
    localparam int unsigned N_ITER      = BIN_W;
    localparam int unsigned ACC_W       = N_INT_DIG * DIG_W;
    localparam int unsigned CNT_W       = 6;

    localparam logic [DIG_W-1:0] SAT_DIGIT = DIG_W'(9);

    typedef enum logic [0:0] {
        IDLE,
        CONV
    } state_t;

    // Displayed digits, index 0 = units
    typedef logic [N_DISP_DIG-1:0][SEG_IN_W-1:0] disp_t;

    // Widen a BCD digit to a decoder code with the upper bits zero
    function automatic logic [SEG_IN_W-1:0] digit_code(input logic [DIG_W-1:0] d);
        return SEG_IN_W'(d);
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle between the LSU/IO output register path and the converter.
// The converter is the slave; the requester drives start/value and reads the digits.
interface bin_to_bcd_seq_if;
    import bin_to_bcd_seq_pkg::*;

    logic                start_i;
    logic [BIN_W-1:0]    bin_i;
    logic                busy_o;
    logic                done_o;
    logic                ovf_o;
    logic [SEG_IN_W-1:0] bcd0_o;
    logic [SEG_IN_W-1:0] bcd1_o;
    logic [SEG_IN_W-1:0] bcd2_o;
    logic [SEG_IN_W-1:0] bcd3_o;
    logic [SEG_IN_W-1:0] bcd4_o;
    logic [SEG_IN_W-1:0] bcd5_o;
    logic [SEG_IN_W-1:0] bcd6_o;
    logic [SEG_IN_W-1:0] bcd7_o;

    modport master (
        output start_i, bin_i,
        input  busy_o, done_o, ovf_o,
        input  bcd0_o, bcd1_o, bcd2_o, bcd3_o, bcd4_o, bcd5_o, bcd6_o, bcd7_o
    );

    modport slave (
        input  start_i, bin_i,
        output busy_o, done_o, ovf_o,
        output bcd0_o, bcd1_o, bcd2_o, bcd3_o, bcd4_o, bcd5_o, bcd6_o, bcd7_o
    );

endinterface

// File: rtl/bin_to_bcd_seq_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more
// so the following left shift carries correctly into the next decade.
module bcd_add3
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [DIG_W-1:0] d,
    output logic [DIG_W-1:0] q_c
);

    always_comb begin
        q_c = (d >= DIG_W'(ADD3_THRESH)) ? d + DIG_W'(3) : d;
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// Results land in registered digit outputs only on completion; nothing moves mid-conversion.
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int unsigned DATA_W  = BIN_W,
    parameter bit          OVF_SAT = 1'b1
)
(
    input  logic             clk_i,
    input  logic             rst_i,
    bin_to_bcd_seq_if.slave  bus
);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [ACC_W-1:0]    acc_q, acc_d, acc_adj;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;
    disp_t               disp_q, disp_d;

    // Per-digit +3 correction on the current accumulator
    for (genvar g = 0; g < int'(N_INT_DIG); g++) begin : g_add3
        bcd_add3 u_add3 (
            .d   (acc_q[g*DIG_W +: DIG_W]),
            .q_c (acc_adj[g*DIG_W +: DIG_W])
        );
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        acc_d   = acc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        disp_d  = disp_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    shift_d = DATA_W'(bus.bin_i);
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = CONV;
                end
            end

            CONV: begin
                // MSB of the binary shift register enters accumulator bit 0
                {acc_d, shift_d} = {acc_adj, shift_q} << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    ovf_d   = |acc_d[ACC_W-1:N_DISP_DIG*DIG_W];
                    for (int i = 0; i < int'(N_DISP_DIG); i++) begin
                        disp_d[i] = (ovf_d && OVF_SAT) ? digit_code(SAT_DIGIT)
                                                       : digit_code(acc_d[i*DIG_W +: DIG_W]);
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            shift_q <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            disp_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            acc_q   <= acc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            disp_q  <= disp_d;
        end
    end

    assign bus.busy_o = busy_q;
    assign bus.done_o = done_q;
    assign bus.ovf_o  = ovf_q;
    assign bus.bcd0_o = disp_q[0];
    assign bus.bcd1_o = disp_q[1];
    assign bus.bcd2_o = disp_q[2];
    assign bus.bcd3_o = disp_q[3];
    assign bus.bcd4_o = disp_q[4];
    assign bus.bcd5_o = disp_q[5];
    assign bus.bcd6_o = disp_q[6];
    assign bus.bcd7_o = disp_q[7];

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: one saturating and one non-saturating instance
// see identical stimulus; expected digits are hand-written BCD constants.
module tb_bin_to_bcd_seq;
    import bin_to_bcd_seq_pkg::*;

    typedef struct {
        logic [31:0] bcd;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst   = 1'b0;
    logic        start = 1'b0;
    logic [31:0] bin   = '0;
    int          cyc    = 0;
    int          n_chk  = 0;
    int          n_fail = 0;
    exp_t        q_a[$];
    exp_t        q_b[$];

    bin_to_bcd_seq_if a_if ();
    bin_to_bcd_seq_if b_if ();

    assign a_if.start_i = start;
    assign a_if.bin_i   = bin;
    assign b_if.start_i = start;
    assign b_if.bin_i   = bin;

    bin_to_bcd_seq #(.DATA_W(32), .OVF_SAT(1'b1)) dut_a (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (a_if)
    );

    bin_to_bcd_seq #(.DATA_W(32), .OVF_SAT(1'b0)) dut_b (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (b_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Hand-written BCD constant (e.g. 32'h12345678) to the eight expected digit codes
    function automatic logic [55:0] codes(input logic [31:0] b);
        logic [55:0] r;
        for (int i = 0; i < 8; i++) r[i*7 +: 7] = {3'b000, b[i*4 +: 4]};
        return r;
    endfunction

    function automatic logic [55:0] digits_a();
        return {a_if.bcd7_o, a_if.bcd6_o, a_if.bcd5_o, a_if.bcd4_o,
                a_if.bcd3_o, a_if.bcd2_o, a_if.bcd1_o, a_if.bcd0_o};
    endfunction

    function automatic logic [55:0] digits_b();
        return {b_if.bcd7_o, b_if.bcd6_o, b_if.bcd5_o, b_if.bcd4_o,
                b_if.bcd3_o, b_if.bcd2_o, b_if.bcd1_o, b_if.bcd0_o};
    endfunction

    // Monitor for the saturating instance
    always @(negedge clk) begin
        if (a_if.done_o === 1'b1) begin
            if (q_a.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL a_unexpected_done: got done at cycle %0d, expected none", cyc);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                chk("a_digits", 64'(digits_a()), 64'(codes(e.bcd)));
                chk("a_ovf", 64'(a_if.ovf_o), 64'(e.ovf));
                chk("a_done_cycle", 64'(cyc), 64'(e.cyc));
                chk("a_busy_at_done", 64'(a_if.busy_o), 64'(0));
            end
        end
    end

    // Monitor for the non-saturating instance
    always @(negedge clk) begin
        if (b_if.done_o === 1'b1) begin
            if (q_b.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL b_unexpected_done: got done at cycle %0d, expected none", cyc);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                chk("b_digits", 64'(digits_b()), 64'(codes(e.bcd)));
                chk("b_ovf", 64'(b_if.ovf_o), 64'(e.ovf));
                chk("b_done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic check_cleared(input string tag);
        chk({tag, "_a_busy"},   64'(a_if.busy_o), 64'(0));
        chk({tag, "_a_done"},   64'(a_if.done_o), 64'(0));
        chk({tag, "_a_ovf"},    64'(a_if.ovf_o),  64'(0));
        chk({tag, "_a_digits"}, 64'(digits_a()),  64'(0));
        chk({tag, "_b_busy"},   64'(b_if.busy_o), 64'(0));
        chk({tag, "_b_digits"}, 64'(digits_b()),  64'(0));
    endtask

    // Caller sits just after a clock edge with both instances idle
    task automatic start_conv(input logic [31:0] v, input logic [31:0] exp_a,
                              input logic [31:0] exp_b, input logic exp_ovf);
        exp_t e;
        bin   = v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e.cyc = cyc + 32;
        e.ovf = exp_ovf;
        e.bcd = exp_a;
        q_a.push_back(e);
        e.bcd = exp_b;
        q_b.push_back(e);
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (a_if.done_o === 1'b1) seen = 1'b1;
        end
        n_chk++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s_timeout: got no done within 40 cycles, expected done", tag);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Asynchronous reset pulse before the first clock edge
        #2 rst = 1'b1;
        #1 check_cleared("reset");
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Busy window and done timing for 12345678
        start_conv(32'd12345678, 32'h12345678, 32'h12345678, 1'b0);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            chk("busy_window", 64'(a_if.busy_o), 64'(1));
            chk("no_early_done", 64'(a_if.done_o), 64'(0));
        end
        @(negedge clk);
        chk("busy_drop", 64'(a_if.busy_o), 64'(0));
        @(posedge clk);
        #1;

        // Back-to-back: second start accepted on the edge ending done
        start_conv(32'd0, 32'h00000000, 32'h00000000, 1'b0);
        wait_done("zero");
        start_conv(32'd99999999, 32'h99999999, 32'h99999999, 1'b0);
        wait_done("nines");

        // Overflow boundary and maximum value
        start_conv(32'd100000000, 32'h99999999, 32'h00000000, 1'b1);
        wait_done("ovf_min");
        start_conv(32'hFFFF_FFFF, 32'h99999999, 32'h94967295, 1'b1);
        wait_done("ovf_max");

        // Start while busy is ignored
        start_conv(32'd55, 32'h00000055, 32'h00000055, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        bin   = 32'd77;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("ignored_start");
        chk("ovf_held", 64'(a_if.ovf_o), 64'(0));

        // Reset at iteration 10 of 4321
        start_conv(32'd4321, 32'h00004321, 32'h00004321, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        chk("busy_mid", 64'(a_if.busy_o), 64'(1));
        #1 rst = 1'b1;
        #1 check_cleared("mid_reset");
        #1 rst = 1'b0;
        q_a.delete();
        q_b.delete();
        repeat (40) @(posedge clk);
        #1;
        check_cleared("post_reset_idle");

        start_conv(32'd4321, 32'h00004321, 32'h00004321, 1'b0);
        wait_done("after_reset");
        repeat (3) @(posedge clk);
        #1;
        chk("a_queue_drained", 64'(q_a.size()), 64'(0));
        chk("b_queue_drained", 64'(q_b.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
